// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM loader: FSM state encodings, ROM image region
// bases and default build parameters.
package rom_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_LOAD  = 2'd1;
  localparam state_t S_WRITE = 2'd2;
  localparam state_t S_HOLD  = 2'd3;

  localparam logic [15:0] ROM128_BASE = 16'h0000;
  localparam logic [15:0] ROM48_BASE  = 16'h8000;
  localparam logic [15:0] ESX_BASE    = 16'hC000;

  localparam logic [15:0] DEFAULT_LAST = 16'hDFFF;
  localparam int          DEFAULT_HOLD = 16;

endpackage

// File: rtl/rom_loader_hold.sv
// Loadable down-counter settle timer: busy while non-zero, expire marks the
// final busy cycle.
module rom_loader_hold #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         busy,
  output logic         expire
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (load)
      cnt <= len;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign busy   = (cnt != '0);
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/rom_loader.sv
// Streams download bytes into the ROM init port and holds the CPU in reset while
// loading. Define ROM_LOADER_CHECKSUM_EN to add a modulo-256 checksum output.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [15:0] LAST = DEFAULT_LAST,
  parameter int          HOLD = DEFAULT_HOLD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        dlEnd,
  input  logic        dlValid,
  output logic        dlReady,
  input  logic [7:0]  dlD,
  output logic        iniBusy,
  output logic        iniWr,
  output logic [7:0]  iniD,
  output logic [15:0] iniA,
  output logic        rstOut,
  output logic        done,
  output logic        overflow,
  output logic [15:0] count
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  sum
`endif
);

  // One extra address bit lets addr park at LAST+1 without wrapping.
  localparam logic [16:0] LAST17   = {1'b0, LAST};
  localparam logic [15:0] HOLD_LEN = 16'(HOLD);

  state_t      state;
  logic [16:0] addr;
  logic        endSeen;
  logic        xfer;
  logic        inRange;
  logic        holdLoad;
  logic        holdBusy;
  logic        holdExpire;

  assign dlReady = (state == S_LOAD);
  assign xfer    = dlValid && dlReady;
  assign inRange = (addr <= LAST17);
  assign rstOut  = !iniBusy;

  assign holdLoad = ((state == S_LOAD) && dlEnd && !xfer) ||
                    ((state == S_WRITE) && (endSeen || dlEnd));

  rom_loader_hold #(.W(16)) u_hold (
    .clock  (clock),
    .reset  (reset),
    .load   (holdLoad),
    .len    (HOLD_LEN),
    .busy   (holdBusy),
    .expire (holdExpire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      addr     <= '0;
      endSeen  <= 1'b0;
      iniBusy  <= 1'b0;
      iniWr    <= 1'b0;
      iniD     <= '0;
      iniA     <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      iniWr <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            iniBusy  <= 1'b1;
            addr     <= {1'b0, ROM128_BASE};
            endSeen  <= 1'b0;
            overflow <= 1'b0;
            count    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (xfer) begin
            iniD    <= dlD;
            iniA    <= addr[15:0];
            iniWr   <= inRange;
            endSeen <= dlEnd;
            state   <= S_WRITE;
          end else if (dlEnd) begin
            state <= S_HOLD;
          end
        end
        S_WRITE: begin
          // Bytes past LAST are dropped; addr stops at LAST+1.
          if (inRange) begin
            count <= count + 16'd1;
            addr  <= addr + 17'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum   <= sum + iniD;
`endif
          end else begin
            overflow <= 1'b1;
          end
          state <= (endSeen || dlEnd) ? S_HOLD : S_LOAD;
        end
        S_HOLD: begin
          if (holdExpire || !holdBusy) begin
            state   <= S_IDLE;
            iniBusy <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Producer side of the memory block's ROM initialisation port (iniBusy/iniWr/iniD/iniA).
- Accepts a byte stream from the download/HPS side through a valid/ready handshake.
- Writes the bytes into the +2 ROM (0x0000-0x7FFF), 48 ROM (0x8000-0xBFFF) and esxDOS ROM (0xC000-0xDFFF) image space in address order.
- Holds the CPU in reset while loading and for a settle period afterwards.

Parameters:
- LAST, 16'hDFFF, highest valid init address; bytes beyond it are discarded.
- HOLD, 16, clock cycles that iniBusy and rstOut stay asserted after the last write.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous reset, active-low; clears all state immediately
- start  input  1  one-cycle pulse; begins a load at address 0x0000
- dlEnd  input  1  one-cycle pulse; stream finished
- dlValid  input  1  dlD holds a byte
- dlReady  output  1  loader can accept a byte this cycle
- dlD  input  8  stream byte
- iniBusy  output  1  init port owns the ROMs
- iniWr  output  1  write strobe, one cycle per byte
- iniD  output  8  write data
- iniA  output  16  write address
- rstOut  output  1  CPU reset, active-low; low while iniBusy
- done  output  1  one-cycle pulse when the load completes
- overflow  output  1  sticky; at least one byte was dropped beyond LAST
- count  output  16  bytes written in the current or last load, saturating at LAST+1

Behaviour:
- Reset values: iniBusy=0, iniWr=0, iniD=0, iniA=0, dlReady=0, rstOut=1, done=0, overflow=0, count=0, state=IDLE.
- IDLE:
  - start -> LOAD; addr=0, count=0, overflow=0.
  - iniBusy=1 and rstOut=0 from the cycle after start.
  - dlValid is ignored in IDLE.
- LOAD:
  - dlReady=1.
  - On dlValid&&dlReady: latch dlD into iniD and addr into iniA, then go to WRITE.
  - dlEnd with no transfer in the same cycle -> HOLD.
- WRITE:
  - dlReady=0.
  - If addr<=LAST: iniWr=1 for exactly this cycle, count+1.
  - Otherwise: iniWr=0 and overflow=1.
  - addr increments and saturates at LAST+1, so it never wraps.
  - Next state: LOAD, or HOLD if dlEnd was seen in the LOAD-transfer cycle or in this cycle.
  - Throughput is one byte every 2 cycles. iniA and iniD are stable for the whole iniWr cycle.
- HOLD:
  - A counter runs HOLD cycles; iniBusy=1, rstOut=0, dlReady=0.
  - At expiry: done=1 for one cycle, iniBusy=0, rstOut=1, state -> IDLE.
- start while not in IDLE is ignored.
- dlEnd in IDLE or HOLD is ignored.
- A transfer and dlEnd in the same LOAD cycle: the byte is written, then the block goes to HOLD.
- An empty load (start, then dlEnd) writes nothing and still completes HOLD and pulses done.
- Reset asserted mid-load aborts immediately; outputs take their reset values. Partially written ROM contents stay as written.
- count and overflow keep their values in IDLE until the next start.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output sum[7:0]: modulo-256 sum of every byte actually written (addr<=LAST).
  - Cleared on start and on reset; valid when done pulses.
- When undefined: no sum port and no adder logic.

Decomposition:
- Shared package holds:
  - State enum IDLE/LOAD/WRITE/HOLD.
  - Region bases ROM128_BASE=16'h0000, ROM48_BASE=16'h8000, ESX_BASE=16'hC000.
  - Default LAST and HOLD.
- One sub-module, rom_loader_hold, is natural: a down-counter with load, expiry pulse and busy flag, also usable as a generic settle timer.

Test Plan:
- start, then 4 bytes AA,55,01,FE with dlValid held high, then dlEnd -> iniWr pulses at iniA 0000..0003 with those data, every other cycle; count=4; done exactly HOLD+1 cycles after the last WRITE; rstOut low throughout.
- Stream 0xE002 bytes -> last iniWr at iniA=DFFF; 2 bytes dropped with no iniWr; overflow=1; count=E000.
- start followed immediately by dlEnd -> no iniWr; done after HOLD cycles; count=0, overflow=0.
- dlValid toggled every third cycle -> each byte written once only; no write without a handshake; dlReady low in WRITE and HOLD.
- Reset pulled low in WRITE at iniA=0x0100 -> iniBusy=0, iniWr=0, rstOut=1 asynchronously; a later start reloads from 0x0000.
- With ROM_LOADER_CHECKSUM_EN: bytes 80,80,01 -> sum=01 at done; a second start clears sum to 00.
